// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver/transmitter FSM encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StData    = 3'd2,
        StStop    = 3'd3,
        StCleanup = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a parameter.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle byte-valid and framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_reg_q, shift_reg_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_dv_q, rx_dv_d;
    logic             frame_err_q, frame_err_d;
    logic             active_q, active_d;
    logic             stop_low_q, stop_low_d;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (i_Clock),
        .rst_n(i_Rst_n),
        .d    (i_Rx_Serial),
        .q    (rx_s)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= StIdle;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_reg_q <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            active_q    <= 1'b0;
            stop_low_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_reg_q <= shift_reg_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            frame_err_q <= frame_err_d;
            active_q    <= active_d;
            stop_low_q  <= stop_low_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_reg_d = shift_reg_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;
        active_d    = active_q;
        stop_low_d  = stop_low_q;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (clk_cnt_q == HALF) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d  = StData;
                        active_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d              = '0;
                    shift_reg_d[bit_idx_q] = rx_s;
                    bit_idx_d              = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = StStop;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d  = '0;
                    active_d   = 1'b0;
                    stop_low_d = !rx_s;
                    state_d    = StCleanup;
                    if (rx_s) begin
                        rx_byte_d = shift_reg_q;
                        rx_dv_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            StCleanup: begin
                // A low stop bit may be a break; wait for the line to recover before rearming.
                if (!stop_low_q || rx_s) begin
                    state_d    = StIdle;
                    stop_low_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign o_Rx_DV        = rx_dv_q;
    assign o_Rx_Byte      = rx_byte_q;
    assign o_Rx_Frame_Err = frame_err_q;
    assign o_Rx_Active    = active_q;

endmodule
